mod_2011_accum: RTL

//   Streaming modular accumulator, stage directly downstream of the mult_3x3_* digit

---
 rtl/mod_2011_accum_if.sv | 30 +++
 rtl/mod_2011_accum.sv | 118 +++++++++++
 2 files changed

// File: rtl/mod_2011_accum_if.sv
// Stream bundle for the mod-2011 accumulator: term input and result output.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both
// high; the producer holds valid and its payload stable until that edge, and the
// consumer may raise or drop ready freely. This holds for both the in_* and out_* sides.
interface mod_2011_accum_if #(
    parameter int W  = 11,
    parameter int CW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_err;

    // Producer of terms and consumer of results.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_err
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_err
    );
endinterface

// File: rtl/mod_2011_accum.sv
// Streaming modular accumulator: sums a framed stream of W-bit residues modulo
// MODULUS one term per cycle, then holds the reduced result until it is taken.
module mod_2011_accum #(
    parameter int W         = 11,
    parameter int MODULUS   = 2011,
    parameter int MAX_TERMS = 16,
    localparam int CW       = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    mod_2011_accum_if.slave   bus,
    output logic              dbg_state   // 0 = ACCUM, 1 = HOLD
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Sum of two W-bit values needs W+1 bits; 2*MODULUS must fit there too.
    localparam logic [W:0]    MOD1    = (W + 1)'(MODULUS);
    localparam logic [W:0]    MOD2    = (W + 1)'(2 * MODULUS);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TERMS);

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          err;

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [CW-1:0] out_count_q;
    logic          out_err_q;

    logic [W:0]    sum;
    logic [W-1:0]  red;
    logic [CW-1:0] cnt_inc;
    logic          err_next;
    logic          accept;
    logic          out_take;

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_err   = out_err_q;
    assign dbg_state     = (state == HOLD);

    assign accept   = bus.in_valid && (state == ACCUM);
    assign out_take = out_valid_q && bus.out_ready;

    // Count saturates at MAX_TERMS; reaching it again marks the frame overlong.
    assign cnt_inc  = (cnt == MAX_CNT) ? MAX_CNT : cnt + CW'(1);
    assign err_next = err | (cnt == MAX_CNT);

    // Add and reduce; acc < MODULUS so at most two subtractions are ever needed,
    // even when the incoming term itself is unreduced.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, bus.in_data};
        red = W'(sum);
        if (sum >= MOD2) begin
            red = W'(sum - MOD2);
        end else if (sum >= MOD1) begin
            red = W'(sum - MOD1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a last term moves to HOLD, the result handshake returns to ACCUM.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (accept && bus.in_last) state_next = HOLD;
            HOLD:  if (out_take)              state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Accumulator, frame counters and the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            if (bus.in_last) begin
                out_data_q  <= red;
                out_count_q <= cnt_inc;
                out_err_q   <= err_next;
                out_valid_q <= 1'b1;
                acc         <= '0;
                cnt         <= '0;
                err         <= 1'b0;
            end else begin
                acc <= red;
                cnt <= cnt_inc;
                err <= err_next;
            end
        end else if (out_take) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
